aes_core: RTL and testbench

- Iterative AES-128 block with separate encrypt and decrypt paths sharing one round-key schedule; one round per clock.
- Sits between a host register interface and downstream logic.
- Encrypts a 128-bit block per FIPS-197, or decrypts it with the inverse cipher.
- Results are held in separate cipher and decrypted_data registers, each with its own done flag.

---
 rtl/aes_pkg.sv | 123 ++++++++++++
 rtl/aes_key_expand.sv | 38 +++
 rtl/aes_core.sv | 110 +++++++++++
 tb/tb_aes_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions.
// Holds the FSM state encoding, the round count, the Rcon and S-box tables,
// GF(2^8) helpers, and the whole-state round transforms (forward and inverse).
// The state is a 128-bit word: byte n is at bits [127-8n -: 8]. Byte n sits
// at row n%4, column n/4.
package aes_pkg;

  localparam int NR = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_DEC  = 2'd2;

  typedef enum logic [1:0] {IDLE = ST_IDLE, ENC = ST_ENC, DEC = ST_DEC} fsm_t;

  localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[b];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] byte_at(input logic [127:0] s, input int n);
    return s[127-8*n -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox(byte_at(s, n));
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(byte_at(s, n));
    return o;
  endfunction

  // Row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = byte_at(s, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = byte_at(s, r + 4*((c + 4 - r) % 4));
    return o;
  endfunction

  // Each output row is a rotation of the coefficient row {2,3,1,1} or {0E,0B,0D,09}
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a [4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      if (inv)
        o[31-8*r -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                         gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
      else
        o[31-8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4] ^
                         a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96], 1'b0), mix_col(s[95:64], 1'b0),
            mix_col(s[63:32], 1'b0), mix_col(s[31:0], 1'b0)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96], 1'b1), mix_col(s[95:64], 1'b1),
            mix_col(s[63:32], 1'b1), mix_col(s[31:0], 1'b1)};
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// aes_key_expand: combinational AES-128 key schedule.
// Ports:
//   key  in   cipher key (rk[0])
//   rk   out  round keys rk[0..10]
module aes_key_expand
  import aes_pkg::*;
(
  input  logic [127:0]       key,
  output logic [10:0][127:0] rk
);

  always_comb begin
    logic [127:0] cur;
    logic [31:0]  t;
    logic [31:0]  w0, w1, w2, w3;
    cur = key;
    t   = '0;
    w0  = '0;
    w1  = '0;
    w2  = '0;
    w3  = '0;
    rk  = '0;
    rk[0] = key;
    for (int r = 1; r <= NR; r++) begin
      // RotWord then SubWord on the last word of the previous round key
      t  = {cur[23:0], cur[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^
           {RCON[r-1], 24'h0};
      w0 = cur[127:96] ^ t;
      w1 = cur[95:64]  ^ w0;
      w2 = cur[63:32]  ^ w1;
      w3 = cur[31:0]   ^ w2;
      cur   = {w0, w1, w2, w3};
      rk[r] = cur;
    end
  end

endmodule

// File: rtl/aes_core.sv
// aes_core: iterative AES-128 encrypt/decrypt, one round per clock.
// Ports:
//   clk, reset                          clock, async active-high reset
//   data, key                           input block and cipher key
//   start_encryption, start_decryption  single-cycle requests (accepted in IDLE)
//   cipher, done_encryption             encryption result and its valid level
//   decrypted_data, done_decryption     decryption result and its valid level
module aes_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data,
  input  logic [127:0] key,
  input  logic         start_encryption,
  input  logic         start_decryption,
  output logic [127:0] cipher,
  output logic [127:0] decrypted_data,
  output logic         done_encryption,
  output logic         done_decryption
);

  localparam logic [3:0] LAST = 4'(NR);

  fsm_t               fsm, fsm_nxt;
  logic [3:0]         round;
  logic [127:0]       st, key_reg, key_src;
  logic [127:0]       enc_base, enc_next, dec_base, dec_next;
  logic [10:0][127:0] rk;

  // While idle the schedule runs from the incoming key, so rk[10] is already
  // available for the initial AddRoundKey of a decryption start.
  assign key_src = (fsm == IDLE) ? key : key_reg;

  aes_key_expand u_key_expand (
    .key (key_src),
    .rk  (rk)
  );

  assign enc_base = shift_rows(sub_bytes(st));
  assign enc_next = (round == LAST) ? (enc_base ^ rk[round])
                                    : (mix_columns(enc_base) ^ rk[round]);
  assign dec_base = inv_sub_bytes(inv_shift_rows(st)) ^ rk[LAST - round];
  assign dec_next = (round == LAST) ? dec_base : inv_mix_columns(dec_base);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: begin
        if (start_encryption)      fsm_nxt = ENC;
        else if (start_decryption) fsm_nxt = DEC;
      end
      ENC, DEC: if (round == LAST) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round           <= '0;
      st              <= '0;
      key_reg         <= '0;
      cipher          <= '0;
      decrypted_data  <= '0;
      done_encryption <= 1'b0;
      done_decryption <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start_encryption) begin
            key_reg         <= key;
            st              <= data ^ key;
            round           <= 4'd1;
            done_encryption <= 1'b0;
          end else if (start_decryption) begin
            key_reg         <= key;
            st              <= data ^ rk[LAST];
            round           <= 4'd1;
            done_decryption <= 1'b0;
          end
        end
        ENC: begin
          st    <= enc_next;
          round <= round + 4'd1;
          if (round == LAST) begin
            cipher          <= enc_next;
            done_encryption <= 1'b1;
            round           <= '0;
          end
        end
        DEC: begin
          st    <= dec_next;
          round <= round + 4'd1;
          if (round == LAST) begin
            decrypted_data  <= dec_next;
            done_decryption <= 1'b1;
            round           <= '0;
          end
        end
        default: round <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core.sv
// tb_aes_core: self-checking bench for aes_core using FIPS-197 vectors.
// Expected results are queued when an operation is started and popped when
// the matching done flag rises.
module tb_aes_core;

  localparam logic [127:0] KEY_KF = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] PT_KF  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] CT_KF  = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] KEY_F  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_F   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_F   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data, key;
  logic         start_encryption, start_decryption;
  logic [127:0] cipher, decrypted_data;
  logic         done_encryption, done_decryption;

  typedef struct {
    bit           is_enc;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  aes_core dut (
    .clk              (clk),
    .reset            (reset),
    .data             (data),
    .key              (key),
    .start_encryption (start_encryption),
    .start_decryption (start_decryption),
    .cipher           (cipher),
    .decrypted_data   (decrypted_data),
    .done_encryption  (done_encryption),
    .done_decryption  (done_decryption)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; the request is taken on the next rising edge.
  // Returns at the falling edge after the accepting edge with junk on the inputs.
  task automatic start_op(input bit se, input bit sd, input logic [127:0] d,
                          input logic [127:0] k, input bit is_enc,
                          input logic [127:0] exp_val);
    data = d;
    key  = k;
    start_encryption = se;
    start_decryption = sd;
    sb.push_back('{is_enc: is_enc, val: exp_val});
    @(negedge clk);
    start_encryption = 1'b0;
    start_decryption = 1'b0;
    data = {$urandom(), $urandom(), $urandom(), $urandom()};
    key  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Cycles until the chosen done flag is seen high, or -1 after 30 cycles
  task automatic wait_done(input bit is_enc, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    for (int n = 1; n <= 30 && !seen; n++) begin
      @(negedge clk);
      if ((is_enc ? done_encryption : done_decryption) === 1'b1) begin
        seen = 1'b1;
        cyc  = n;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_encryption = 1'b0;
    start_decryption = 1'b0;
    data = '0;
    key  = '0;
    repeat (2) @(negedge clk);
    checks++; if (cipher !== '0) begin failures++; $display("FAIL reset_cipher got=%h want=0", cipher); end
    checks++; if (decrypted_data !== '0) begin failures++; $display("FAIL reset_decrypted got=%h want=0", decrypted_data); end
    checks++; if (done_encryption !== 1'b0) begin failures++; $display("FAIL reset_done_enc got=%b want=0", done_encryption); end
    checks++; if (done_decryption !== 1'b0) begin failures++; $display("FAIL reset_done_dec got=%b want=0", done_decryption); end
    reset = 1'b0;
  endtask

  task automatic test_encrypt_kungfu();
    exp_t e;
    int   cyc;
    start_op(1'b1, 1'b0, PT_KF, KEY_KF, 1'b1, CT_KF);
    wait_done(1'b1, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL enc_kf_latency got=%0d want=10", cyc); end
    checks++; if (cipher !== e.val) begin failures++; $display("FAIL enc_kf_cipher got=%h want=%h", cipher, e.val); end
    checks++; if (done_decryption !== 1'b0) begin failures++; $display("FAIL enc_kf_done_dec got=%b want=0", done_decryption); end
  endtask

  task automatic test_decrypt_kungfu();
    exp_t e;
    int   cyc;
    start_op(1'b0, 1'b1, CT_KF, KEY_KF, 1'b0, PT_KF);
    wait_done(1'b0, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL dec_kf_latency got=%0d want=10", cyc); end
    checks++; if (decrypted_data !== e.val) begin failures++; $display("FAIL dec_kf_data got=%h want=%h", decrypted_data, e.val); end
    checks++; if (cipher !== CT_KF) begin failures++; $display("FAIL dec_kf_cipher_kept got=%h want=%h", cipher, CT_KF); end
    checks++; if (done_encryption !== 1'b1) begin failures++; $display("FAIL dec_kf_done_enc_kept got=%b want=1", done_encryption); end
  endtask

  task automatic test_encrypt_fips();
    exp_t e;
    int   cyc;
    start_op(1'b1, 1'b0, PT_F, KEY_F, 1'b1, CT_F);
    wait_done(1'b1, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL enc_fips_latency got=%0d want=10", cyc); end
    checks++; if (cipher !== e.val) begin failures++; $display("FAIL enc_fips_cipher got=%h want=%h", cipher, e.val); end
    checks++; if (decrypted_data !== PT_KF) begin failures++; $display("FAIL enc_fips_dec_kept got=%h want=%h", decrypted_data, PT_KF); end
    checks++; if (done_decryption !== 1'b1) begin failures++; $display("FAIL enc_fips_done_dec_kept got=%b want=1", done_decryption); end
  endtask

  task automatic test_decrypt_fips();
    exp_t e;
    int   cyc;
    start_op(1'b0, 1'b1, CT_F, KEY_F, 1'b0, PT_F);
    wait_done(1'b0, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL dec_fips_latency got=%0d want=10", cyc); end
    checks++; if (decrypted_data !== e.val) begin failures++; $display("FAIL dec_fips_data got=%h want=%h", decrypted_data, e.val); end
    repeat (5) @(negedge clk);
    checks++; if (done_encryption !== 1'b1) begin failures++; $display("FAIL done_enc_level got=%b want=1", done_encryption); end
    checks++; if (done_decryption !== 1'b1) begin failures++; $display("FAIL done_dec_level got=%b want=1", done_decryption); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    start_op(1'b1, 1'b0, PT_KF, KEY_KF, 1'b1, CT_KF);
    checks++; if (done_encryption !== 1'b0) begin failures++; $display("FAIL b2b_done_enc_cleared got=%b want=0", done_encryption); end
    checks++; if (done_decryption !== 1'b1) begin failures++; $display("FAIL b2b_done_dec_held got=%b want=1", done_decryption); end
    wait_done(1'b1, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL b2b_first_latency got=%0d want=10", cyc); end
    checks++; if (cipher !== e.val) begin failures++; $display("FAIL b2b_first_cipher got=%h want=%h", cipher, e.val); end
    start_op(1'b1, 1'b0, PT_F, KEY_F, 1'b1, CT_F);
    wait_done(1'b1, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL b2b_second_latency got=%0d want=10", cyc); end
    checks++; if (cipher !== e.val) begin failures++; $display("FAIL b2b_second_cipher got=%h want=%h", cipher, e.val); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   cyc;
    start_op(1'b1, 1'b0, PT_KF, KEY_KF, 1'b1, CT_KF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (cipher !== '0) begin failures++; $display("FAIL abort_cipher got=%h want=0", cipher); end
    checks++; if (decrypted_data !== '0) begin failures++; $display("FAIL abort_decrypted got=%h want=0", decrypted_data); end
    checks++; if (done_encryption !== 1'b0) begin failures++; $display("FAIL abort_done_enc got=%b want=0", done_encryption); end
    checks++; if (done_decryption !== 1'b0) begin failures++; $display("FAIL abort_done_dec got=%b want=0", done_decryption); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    wait_done(1'b1, cyc);
    checks++; if (cyc != -1) begin failures++; $display("FAIL abort_no_done got=%0d want=-1", cyc); end
    checks++; if (cipher !== '0) begin failures++; $display("FAIL abort_no_partial got=%h want=0", cipher); end
    start_op(1'b1, 1'b0, PT_F, KEY_F, 1'b1, CT_F);
    wait_done(1'b1, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL abort_restart_latency got=%0d want=10", cyc); end
    checks++; if (cipher !== e.val) begin failures++; $display("FAIL abort_restart_cipher got=%h want=%h", cipher, e.val); end
  endtask

  task automatic test_both_starts();
    exp_t e;
    int   cyc;
    start_op(1'b1, 1'b1, PT_KF, KEY_KF, 1'b1, CT_KF);
    wait_done(1'b1, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 10) begin failures++; $display("FAIL both_latency got=%0d want=10", cyc); end
    checks++; if (cipher !== e.val) begin failures++; $display("FAIL both_cipher got=%h want=%h", cipher, e.val); end
    checks++; if (done_decryption !== 1'b0) begin failures++; $display("FAIL both_done_dec got=%b want=0", done_decryption); end
    checks++; if (decrypted_data !== '0) begin failures++; $display("FAIL both_decrypted got=%h want=0", decrypted_data); end
  endtask

  task automatic test_busy_start();
    exp_t e;
    int   cyc;
    start_op(1'b1, 1'b0, PT_F, KEY_F, 1'b1, CT_F);
    repeat (3) @(negedge clk);
    data = PT_KF;
    key  = KEY_KF;
    start_encryption = 1'b1;
    start_decryption = 1'b1;
    @(negedge clk);
    start_encryption = 1'b0;
    start_decryption = 1'b0;
    wait_done(1'b1, cyc);
    e = sb.pop_front();
    checks++; if (cyc != 6) begin failures++; $display("FAIL busy_latency got=%0d want=6", cyc); end
    checks++; if (cipher !== e.val) begin failures++; $display("FAIL busy_cipher got=%h want=%h", cipher, e.val); end
    checks++; if (done_decryption !== 1'b0) begin failures++; $display("FAIL busy_done_dec got=%b want=0", done_decryption); end
  endtask

  initial begin
    test_reset();
    test_encrypt_kungfu();
    test_decrypt_kungfu();
    test_encrypt_fips();
    test_decrypt_fips();
    test_back_to_back();
    test_reset_abort();
    test_both_starts();
    test_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
